// File: rtl/seq_det_pkg.sv
// seq_det_pkg: types and defaults shared by the bit serializer
// and the downstream serial sequence detector.
package seq_det_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_DEPTH  = 4;

    // Serializer shifter states.
    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        PARITY
    } ser_state_t;

    // Sequence detector states (1011 pattern).
    typedef enum logic [2:0] {
        S_NONE,
        S_1,
        S_10,
        S_101,
        S_1011
    } state_t;

    // Pointer width with one extra wrap bit.
    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/ser_fifo.sv
// ser_fifo: synchronous FIFO feeding the serializer shifter.
// Ports: clk, reset_i (sync, active-low), push_i/din_i, pop_i, dout_o, full_o, empty_o.
module ser_fifo
    import seq_det_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic              clk,
    input  logic              reset_i,
    input  logic              push_i,
    input  logic [DATA_W-1:0] din_i,
    input  logic              pop_i,
    output logic [DATA_W-1:0] dout_o,
    output logic              full_o,
    output logic              empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = ptr_w(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PW-1:0]     wptr_q;
    logic [PW-1:0]     wptr_d;
    logic [PW-1:0]     rptr_q;
    logic [PW-1:0]     rptr_d;
    logic              do_push;
    logic              do_pop;

    // Same index, different wrap bit: full.
    assign full_o  = (wptr_q[AW] != rptr_q[AW]) &&
                     (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign empty_o = (wptr_q == rptr_q);

    // A full FIFO refuses a push even if a pop happens this cycle.
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    assign wptr_d = wptr_q + {{(PW-1){1'b0}}, do_push};
    assign rptr_d = rptr_q + {{(PW-1){1'b0}}, do_pop};

    assign dout_o = mem_q[rptr_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!reset_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wptr_q[AW-1:0]] <= din_i;
        end
    end

endmodule

// File: rtl/bit_serializer.sv
// bit_serializer: buffers parallel words and emits them one bit per clock.
// Ports: clk, reset_i (sync, active-low), data_i/valid_i/ready_o handshake,
//        bit_o/bit_valid_o serial stream, frame_start_o, busy_o.
// Optional: define BIT_SERIALIZER_PARITY_EN to append an even-parity bit per word.
module bit_serializer
    import seq_det_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int DEPTH     = DEF_DEPTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              reset_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              valid_i,
    output logic              ready_o,
    output logic              bit_o,
    output logic              bit_valid_o,
    output logic              frame_start_o,
    output logic              busy_o
);

    localparam int            CW      = $clog2(DATA_W);
    localparam logic [CW-1:0] CNT_TOP = CW'(DATA_W - 1);

    ser_state_t        state_q;
    logic [DATA_W-1:0] sh_q;
    logic [CW-1:0]     cnt_q;
    logic              bit_q;
    logic              bv_q;
    logic              fs_q;
    logic              busy_q;
`ifdef BIT_SERIALIZER_PARITY_EN
    logic              par_q;
`endif

    logic              fifo_full;
    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_dout;
    logic              load_d;
    logic              head;
    logic [DATA_W-1:0] sh_d;
    logic              last;

    ser_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_i (reset_i),
        .push_i  (valid_i),
        .din_i   (data_i),
        .pop_i   (load_d),
        .dout_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign ready_o = !fifo_full;
    assign last    = (cnt_q == '0);

    always_comb begin
        if (MSB_FIRST) begin
            head = sh_q[DATA_W-1];
            sh_d = {sh_q[DATA_W-2:0], 1'b0};
        end else begin
            head = sh_q[0];
            sh_d = {1'b0, sh_q[DATA_W-1:1]};
        end
    end

    // Pop/reload points: idle, end of word (or parity slot).
    always_comb begin
        load_d = 1'b0;
        unique case (state_q)
            IDLE:    load_d = !fifo_empty;
`ifdef BIT_SERIALIZER_PARITY_EN
            SHIFT:   load_d = 1'b0;
            PARITY:  load_d = !fifo_empty;
`else
            SHIFT:   load_d = last && !fifo_empty;
`endif
            default: load_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_i) begin
            state_q <= IDLE;
            sh_q    <= '0;
            cnt_q   <= '0;
            bit_q   <= 1'b0;
            bv_q    <= 1'b0;
            fs_q    <= 1'b0;
            busy_q  <= 1'b0;
`ifdef BIT_SERIALIZER_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            bit_q  <= 1'b0;
            bv_q   <= 1'b0;
            fs_q   <= 1'b0;
            busy_q <= (state_q != IDLE) || !fifo_empty;
            unique case (state_q)
                IDLE: begin
                    state_q <= IDLE;
                end
                SHIFT: begin
                    bit_q <= head;
                    bv_q  <= 1'b1;
                    fs_q  <= (cnt_q == CNT_TOP);
                    sh_q  <= sh_d;
                    cnt_q <= cnt_q - CW'(1);
                    if (last) begin
`ifdef BIT_SERIALIZER_PARITY_EN
                        state_q <= PARITY;
`else
                        state_q <= IDLE;
`endif
                    end
                end
`ifdef BIT_SERIALIZER_PARITY_EN
                PARITY: begin
                    bit_q   <= par_q;
                    bv_q    <= 1'b1;
                    state_q <= IDLE;
                end
`endif
                default: begin
                    state_q <= IDLE;
                end
            endcase
            // Reload overrides the end-of-word exit for zero-gap chaining.
            if (load_d) begin
                sh_q    <= fifo_dout;
                cnt_q   <= CNT_TOP;
                state_q <= SHIFT;
`ifdef BIT_SERIALIZER_PARITY_EN
                par_q   <= ^fifo_dout;
`endif
            end
        end
    end

    assign bit_o         = bit_q;
    assign bit_valid_o   = bv_q;
    assign frame_start_o = fs_q;
    assign busy_o        = busy_q;

endmodule
